// File: rtl/prbs16_checker.sv
// Self-synchronising checker for the x^16+x^15+1 PRBS stream: hunt, verify, lock, count errors.
// Optional `PRBS16_CHK_AUTO_RESYNC_EN: on loss of sync, drop lock and re-hunt automatically.
module prbs16_checker #(
   parameter int unsigned LOCK_CNT = 32,
   parameter int unsigned WINDOW   = 64,
   parameter int unsigned LOSS_ERR = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bit_in,
   input  logic        bit_vld,
   input  logic        clr_cnt,
   output logic        lock,
   output logic        err_pulse,
   output logic [15:0] err_cnt,
   output logic        sync_loss
);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t      r_state;
   logic [15:0] r_hist;
   logic [3:0]  r_fill;
   logic [7:0]  r_match;
   logic [7:0]  r_wbits;
   logic [7:0]  r_werrs;
   logic        r_lock;
   logic        r_err_pulse;
   logic [15:0] r_err_cnt;
   logic        r_sync_loss;

   logic        w_pred;
   logic        w_err;
   logic [7:0]  w_wbits_nxt;
   logic [7:0]  w_werrs_nxt;
   logic        w_win_end;
   logic        w_loss;

   always_comb begin
      w_pred      = r_hist[15] ^ r_hist[14];
      w_err       = bit_in ^ w_pred;
      w_wbits_nxt = r_wbits + 8'd1;
      w_werrs_nxt = r_werrs + {7'd0, w_err};
      w_win_end   = (w_wbits_nxt == 8'(WINDOW));
      // Fires once per window, on the error that brings the count to the threshold.
      w_loss      = w_err && (w_werrs_nxt == 8'(LOSS_ERR));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= HUNT;
         r_hist      <= '0;
         r_fill      <= '0;
         r_match     <= '0;
         r_wbits     <= '0;
         r_werrs     <= '0;
         r_lock      <= 1'b0;
         r_err_pulse <= 1'b0;
         r_err_cnt   <= '0;
         r_sync_loss <= 1'b0;
      end else begin
         r_err_pulse <= 1'b0;
         if (bit_vld) begin
            case (r_state)
               HUNT: begin
                  r_hist <= {r_hist[14:0], bit_in};
                  if (r_fill == 4'd15) begin
                     r_fill  <= '0;
                     r_match <= '0;
                     r_state <= VERIFY;
                  end else begin
                     r_fill <= r_fill + 4'd1;
                  end
               end
               VERIFY: begin
                  if (r_hist == '0) begin
                     r_fill  <= '0;
                     r_state <= HUNT;
                  end else begin
                     r_hist <= {r_hist[14:0], bit_in};
                     if (w_err) begin
                        r_fill  <= '0;
                        r_state <= HUNT;
                     end else if (r_match == 8'(LOCK_CNT - 1)) begin
                        r_wbits <= '0;
                        r_werrs <= '0;
                        r_lock  <= 1'b1;
                        r_state <= LOCKED;
                     end else begin
                        r_match <= r_match + 8'd1;
                     end
                  end
               end
               LOCKED: begin
                  // Free-running local generator: the received bit never enters hist.
                  r_hist <= {r_hist[14:0], w_pred};
                  if (w_err) begin
                     r_err_pulse <= 1'b1;
                     if (r_err_cnt != 16'hFFFF)
                        r_err_cnt <= r_err_cnt + 16'd1;
                  end
                  if (w_win_end) begin
                     r_wbits <= '0;
                     r_werrs <= '0;
                  end else begin
                     r_wbits <= w_wbits_nxt;
                     r_werrs <= w_werrs_nxt;
                  end
                  if (w_loss) begin
                     r_sync_loss <= 1'b1;
`ifdef PRBS16_CHK_AUTO_RESYNC_EN
                     r_fill  <= '0;
                     r_lock  <= 1'b0;
                     r_state <= HUNT;
`endif
                  end
               end
               default: begin
                  r_fill  <= '0;
                  r_lock  <= 1'b0;
                  r_state <= HUNT;
               end
            endcase
         end
         if (clr_cnt) begin
            r_err_cnt   <= '0;
            r_sync_loss <= 1'b0;
         end
      end
   end

   assign lock      = r_lock;
   assign err_pulse = r_err_pulse;
   assign err_cnt   = r_err_cnt;
   assign sync_loss = r_sync_loss;

endmodule

// File: tb/tb_prbs16_checker.sv
// Directed self-checking bench for prbs16_checker (default parameters).
module tb_prbs16_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        bit_in = 1'b0;
   logic        bit_vld = 1'b0;
   logic        clr_cnt = 1'b0;
   logic        lock;
   logic        err_pulse;
   logic [15:0] err_cnt;
   logic        sync_loss;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [15:0] g;
   int unsigned vcount;
   int unsigned pulse_cnt;
   logic        saw_lock;

   prbs16_checker #(.LOCK_CNT(32), .WINDOW(64), .LOSS_ERR(8)) dut (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld), .clr_cnt(clr_cnt),
      .lock(lock), .err_pulse(err_pulse), .err_cnt(err_cnt), .sync_loss(sync_loss)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle; outputs are sampled 1 time unit after the edge.
   task automatic send_raw(input logic b, input logic vld, input logic clr);
      bit_in  = b;
      bit_vld = vld;
      clr_cnt = clr;
      @(posedge clk);
      #1;
      if (err_pulse === 1'b1) pulse_cnt++;
      if (lock === 1'b1) saw_lock = 1'b1;
   endtask

   task automatic send(input logic flip, input logic vld, input logic clr);
      logic nb;
      if (vld) begin
         nb = g[15] ^ g[14];
         g = {g[14:0], nb};
         vcount++;
         send_raw(nb ^ flip, 1'b1, clr);
      end else begin
         send_raw(~bit_in, 1'b0, clr);
      end
   endtask

   task automatic clean(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) send(1'b0, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      bit_vld = 1'b0;
      clr_cnt = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      g = 16'h0001;
      vcount = 0;
      pulse_cnt = 0;
      saw_lock = 1'b0;
   endtask

   initial begin
      // Reset values
      #2;
      check("rst_lock", {15'd0, lock}, 16'd0);
      check("rst_pulse", {15'd0, err_pulse}, 16'd0);
      check("rst_errcnt", err_cnt, 16'd0);
      check("rst_syncloss", {15'd0, sync_loss}, 16'd0);

      // A: clean continuous stream
      do_reset();
      clean(47);
      check("A_nolock47", {15'd0, lock}, 16'd0);
      clean(1);
      check("A_lock48", {15'd0, lock}, 16'd1);
      clean(952);
      check("A_lock1000", {15'd0, lock}, 16'd1);
      check("A_errcnt", err_cnt, 16'd0);
      check("A_pulses", 16'(pulse_cnt), 16'd0);

      // B: bit_vld alternating, garbage on invalid cycles
      do_reset();
      for (int unsigned i = 0; i < 47; i++) begin
         send(1'b0, 1'b1, 1'b0);
         send(1'b0, 1'b0, 1'b0);
      end
      check("B_nolock47", {15'd0, lock}, 16'd0);
      send(1'b0, 1'b1, 1'b0);
      check("B_lock48", {15'd0, lock}, 16'd1);
      for (int unsigned i = 0; i < 200; i++) begin
         send(1'b0, 1'b0, 1'b0);
         send(1'b0, 1'b1, 1'b0);
      end
      check("B_errcnt", err_cnt, 16'd0);
      check("B_pulses", 16'(pulse_cnt), 16'd0);
      check("B_lock", {15'd0, lock}, 16'd1);

      // C: single flipped bit at valid index 100
      do_reset();
      clean(99);
      send(1'b1, 1'b1, 1'b0);
      check("C_pulse", {15'd0, err_pulse}, 16'd1);
      check("C_errcnt1", err_cnt, 16'd1);
      check("C_lock", {15'd0, lock}, 16'd1);
      clean(1);
      check("C_pulse_gone", {15'd0, err_pulse}, 16'd0);
      clean(200);
      check("C_pulses", 16'(pulse_cnt), 16'd1);
      check("C_errcnt_final", err_cnt, 16'd1);

      // D: burst of 8 flipped bits (120..127) inside one window
      do_reset();
      clean(119);
      for (int unsigned i = 0; i < 7; i++) send(1'b1, 1'b1, 1'b0);
      check("D_noloss7", {15'd0, sync_loss}, 16'd0);
      check("D_errcnt7", err_cnt, 16'd7);
      send(1'b1, 1'b1, 1'b0);
      check("D_loss8", {15'd0, sync_loss}, 16'd1);
      check("D_errcnt8", err_cnt, 16'd8);
`ifdef PRBS16_CHK_AUTO_RESYNC_EN
      check("D_lockdrop", {15'd0, lock}, 16'd0);
      clean(47);
      check("D_nolock47", {15'd0, lock}, 16'd0);
      clean(1);
      check("D_relock", {15'd0, lock}, 16'd1);
`else
      check("D_lockhold", {15'd0, lock}, 16'd1);
      clean(50);
      check("D_lockhold2", {15'd0, lock}, 16'd1);
      check("D_errcnt_hold", err_cnt, 16'd8);
`endif
      check("D_sticky", {15'd0, sync_loss}, 16'd1);

      // Async reset while locked with nonzero counters
      #3;
      rst = 1'b1;
      #1;
      check("R_lock", {15'd0, lock}, 16'd0);
      check("R_errcnt", err_cnt, 16'd0);
      check("R_syncloss", {15'd0, sync_loss}, 16'd0);

      // E: clr_cnt coinciding with an error at err_cnt=5
      do_reset();
      clean(59);
      send(1'b1, 1'b1, 1'b0);   // 60
      clean(9);
      send(1'b1, 1'b1, 1'b0);   // 70
      clean(9);
      send(1'b1, 1'b1, 1'b0);   // 80
      clean(9);
      send(1'b1, 1'b1, 1'b0);   // 90
      clean(9);
      send(1'b1, 1'b1, 1'b0);   // 100
      check("E_errcnt5", err_cnt, 16'd5);
      clean(4);
      send(1'b1, 1'b1, 1'b1);   // 105 with clr_cnt
      check("E_clr_errcnt", err_cnt, 16'd0);
      check("E_clr_pulse", {15'd0, err_pulse}, 16'd1);
      clean(1);
      check("E_after_pulse", {15'd0, err_pulse}, 16'd0);
      check("E_after_cnt", err_cnt, 16'd0);
      check("E_lock", {15'd0, lock}, 16'd1);

      // F: stuck-at lines never lock
      do_reset();
      for (int unsigned i = 0; i < 500; i++) send_raw(1'b0, 1'b1, 1'b0);
      check("F_stuck0_lock", {15'd0, saw_lock}, 16'd0);
      check("F_stuck0_cnt", err_cnt, 16'd0);
      do_reset();
      for (int unsigned i = 0; i < 500; i++) send_raw(1'b1, 1'b1, 1'b0);
      check("F_stuck1_lock", {15'd0, saw_lock}, 16'd0);
      check("F_stuck1_cnt", err_cnt, 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prbs16_checker.md
# prbs16_checker

Serial pattern checker for the 16-bit PRBS stream produced by the team's on-chip LFSR generator (recurrence b[n] = b[n-16] XOR b[n-15], i.e. each generated bit is the XOR of history taps 15 and 14).
- Sits at the receive end of a loopback or test path.
- Self-synchronises to the incoming bit stream, declares lock, then counts bit errors against a locally regenerated sequence.
- Flags loss of synchronisation on an error burst.

## Interface
Parameters:
- LOCK_CNT, 32: consecutive correctly predicted bits in VERIFY required to declare lock (1..255).
- WINDOW, 64: length, in valid bits, of the loss-of-sync error window in LOCKED (2..255).
- LOSS_ERR, 8: errors within one window that trigger loss of sync (1..WINDOW).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- bit_in  in  1  received serial data bit.
- bit_vld  in  1  bit_in is sampled only on cycles with bit_vld=1.
- clr_cnt  in  1  synchronous clear of err_cnt and sync_loss.
- lock  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse per detected bit error in LOCKED.
- err_cnt  out  16  total errors while LOCKED, saturating at 0xFFFF.
- sync_loss  out  1  sticky loss-of-sync flag.

## Operation
- Internal state:
  - hist[15:0]: history, hist[0] = newest bit.
  - pred = hist[15] ^ hist[14].
  - fill counter (0..15), match counter, window bit counter, window error counter.
- All counters and hist advance only on bit_vld=1; with bit_vld=0 nothing changes and err_pulse=0.
- FSM:
  - HUNT: shift bit_in into hist; after the 16th valid bit go to VERIFY with match counter=0.
  - VERIFY:
    - If hist==0, go to HUNT with fill counter=0. This blocks false lock on a stuck-at-0 line.
    - Otherwise compare bit_in with pred and shift bit_in into hist.
    - Mismatch: go to HUNT with fill counter=0.
    - Match: increment the match counter. When it reaches LOCK_CNT, go to LOCKED with window counters cleared.
  - LOCKED:
    - Shift pred, not bit_in, into hist (free-running local generator), so one flipped input bit gives exactly one error.
    - On mismatch: err_pulse=1, err_cnt increments (saturating), window error counter increments.
    - When the window error count reaches LOSS_ERR, the loss-of-sync event fires on that bit (see Configuration).
    - The window bit counter increments on every valid bit. The bit that reaches WINDOW is first evaluated for loss, then both window counters clear.
- clr_cnt:
  - Zeroes err_cnt and sync_loss.
  - Takes priority over a simultaneous increment or set (that error is not counted, but err_pulse still asserts).
  - Does not affect the FSM or the window counters.
- Reset values: all outputs 0; FSM=HUNT; hist, fill counter, match counter and window counters all 0.

## Timing
- All outputs are registered. They reflect the valid bit sampled on the previous rising edge.
- Lock latency from reset with a clean stream: 16 + LOCK_CNT valid bits (48 with defaults). lock rises the cycle after the last of those bits.
- err_pulse is high for exactly one cycle, the cycle after the erroneous valid bit. err_cnt updates on the same edge.
- Loss of sync: lock (with auto-resync) or sync_loss rises or falls the cycle after the LOSS_ERR-th windowed error.
- rst mid-operation: all outputs are 0 immediately (asynchronous) and remain so until after release. Relocking needs the full lock latency again.

## Configuration
- PRBS16_CHK_AUTO_RESYNC_EN defined:
  - A loss-of-sync event sets sync_loss.
  - The FSM goes to HUNT with fill counter=0, and lock falls.
  - Relock is automatic.
- Not defined:
  - A loss-of-sync event sets sync_loss only.
  - The FSM stays in LOCKED and keeps counting. Window counters clear and evaluation continues.
  - Recovery only by rst.

## Test plan
- Clean PRBS16 stream from seed 0x0001, bit_vld=1 continuously -> lock=1 the cycle after valid bit 48; err_cnt stays 0 for 1000 bits.
- Same stream, bit_vld toggled 1/0 alternately -> lock after 48 valid bits (96 cycles); no errors.
- After lock, invert the single bit at valid index 100 -> exactly one err_pulse, err_cnt=1, lock stays 1, no follow-on errors.
- After lock, invert 8 consecutive bits:
  - Macro defined: sync_loss=1 and lock=0 the cycle after the 8th error; relock 48 clean bits later.
  - Macro undefined: sync_loss=1, lock stays 1, err_cnt=8.
- bit_in held 0 (or 1) from reset for 500 bits -> lock never asserts, err_cnt=0.
- Assert clr_cnt on the same cycle as an error, with err_cnt=5 -> err_cnt=0, err_pulse=1. Assert rst while locked -> lock, err_cnt and sync_loss are 0 immediately.
